// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: operation codes, ALUOp classes,
// funct field constants and the shift-amount width.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_ADD     = 4'b0010,
    OP_SLLI    = 4'b0100,
    OP_SRLI    = 4'b0101,
    OP_EQ      = 4'b1000,
    OP_ILLEGAL = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam int         SHAMT_WIDTH = 5;

endpackage

// File: rtl/alu_issue_if.sv
// ID->EX issue bus: decoded fields and operands in, ALU operands/operation out.
// master = environment driving the stage, slave = the issue stage itself.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     InValid;
  logic                     InReady;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic                     ALUSrc;
  logic [DATA_WIDTH-1:0]    RD1;
  logic [DATA_WIDTH-1:0]    RD2;
  logic [DATA_WIDTH-1:0]    ImmG;
  logic                     Flush;
  logic                     OutValid;
  logic                     OutReady;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     Illegal;
  logic [7:0]               IllegalCount;

  modport master (
    output InValid, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, ImmG, Flush, OutReady,
    input  InReady, OutValid, SrcA, SrcB, Operation, Illegal, IllegalCount
  );

  modport slave (
    input  InValid, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, ImmG, Flush, OutReady,
    output InReady, OutValid, SrcA, SrcB, Operation, Illegal, IllegalCount
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALU control: ALUOp/Funct3/Funct7 -> operation code + illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    operation,
  output logic       illegal
);

  always_comb begin
    operation = OP_ILLEGAL;
    case (alu_op)
      ALUOP_MEM:    operation = OP_ADD;
      ALUOP_BRANCH: if (funct3 == F3_ADD) operation = OP_EQ;
      ALUOP_RTYPE: begin
        if (funct7 == FUNCT7_ZERO) begin
          case (funct3)
            F3_ADD:  operation = OP_ADD;
            F3_AND:  operation = OP_AND;
            F3_OR:   operation = OP_OR;
            default: operation = OP_ILLEGAL;
          endcase
        end
      end
      ALUOP_ITYPE: begin
        // Logical/arith immediates ignore funct7; only shifts require it clear
        case (funct3)
          F3_ADD:  operation = OP_ADD;
          F3_AND:  operation = OP_AND;
          F3_OR:   operation = OP_OR;
          F3_SLL:  if (funct7 == FUNCT7_ZERO) operation = OP_SLLI;
          F3_SRL:  if (funct7 == FUNCT7_ZERO) operation = OP_SRLI;
          default: operation = OP_ILLEGAL;
        endcase
      end
      default: operation = OP_ILLEGAL;
    endcase
    illegal = (operation == OP_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue.sv
// Registered ID->EX issue stage: decodes the ALU operation, selects/masks SrcB
// and holds the result in a single-entry valid/ready register with flush.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] src_a_q, src_a_d;
  logic [DATA_WIDTH-1:0] src_b_q, src_b_d;
  alu_op_e               op_q, op_d;
  logic                  illegal_q, illegal_d;
  logic [7:0]            ill_cnt_q, ill_cnt_d;

  alu_op_e               dec_op;
  logic                  dec_illegal;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  in_ready;
  logic                  xfer_in;
  logic                  xfer_out;

  alu_op_decode u_dec (
    .alu_op    (bus.ALUOp),
    .funct3    (bus.Funct3),
    .funct7    (bus.Funct7),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  assign is_shift = (dec_op == OP_SLLI) || (dec_op == OP_SRLI);
  assign sel_b    = bus.ALUSrc ? bus.ImmG : bus.RD2;
  assign in_ready = (!out_valid_q || bus.OutReady) && !bus.Flush;
  assign xfer_in  = bus.InValid && in_ready;
  assign xfer_out = out_valid_q && bus.OutReady;

  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    ill_cnt_d   = ill_cnt_q;

    if (xfer_in) begin
      op_d      = dec_op;
      illegal_d = dec_illegal;
      src_a_d   = dec_illegal ? '0 : bus.RD1;
      if (dec_illegal)   src_b_d = '0;
      else if (is_shift) src_b_d = DATA_WIDTH'(sel_b[SHAMT_WIDTH-1:0]);
      else               src_b_d = sel_b;
    end

    // Flush drops the held entry outright, so it is neither issued nor counted
    if (bus.Flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (xfer_in)       out_valid_d = 1'b1;
      else if (xfer_out) out_valid_d = 1'b0;
      if (xfer_out && illegal_q && !(&ill_cnt_q)) ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      op_q        <= OP_AND;
      illegal_q   <= 1'b0;
      ill_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign bus.InReady      = in_ready;
  assign bus.OutValid     = out_valid_q;
  assign bus.SrcA         = src_a_q;
  assign bus.SrcB         = src_b_q;
  assign bus.Operation    = OPCODE_LENGTH'(op_q);
  assign bus.Illegal      = illegal_q;
  assign bus.IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the issue stage.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model of the registered stage
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  bit          m_ill;
  logic [7:0]  m_cnt;

  function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [3:0] op;
    op = 4'hF;
    if (aop == 2'd0) op = 4'h2;
    else if (aop == 2'd1) begin
      if (f3 == 3'd0) op = 4'h8;
    end else if (aop == 2'd2) begin
      if (f7 == 7'd0 && f3 == 3'd0) op = 4'h2;
      if (f7 == 7'd0 && f3 == 3'd7) op = 4'h0;
      if (f7 == 7'd0 && f3 == 3'd6) op = 4'h1;
    end else begin
      if (f3 == 3'd0) op = 4'h2;
      if (f3 == 3'd7) op = 4'h0;
      if (f3 == 3'd6) op = 4'h1;
      if (f3 == 3'd1 && f7 == 7'd0) op = 4'h4;
      if (f3 == 3'd5 && f7 == 7'd0) op = 4'h5;
    end
    return op;
  endfunction

  function automatic bit exp_ready();
    return (!m_valid || bus.OutReady) && !bus.Flush;
  endfunction

  task automatic drive(input bit v, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input bit src, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm);
    bus.InValid = v; bus.ALUOp = aop; bus.Funct3 = f3; bus.Funct7 = f7;
    bus.ALUSrc = src; bus.RD1 = rd1; bus.RD2 = rd2; bus.ImmG = imm;
  endtask

  task automatic drive_rand(input bit v);
    logic [6:0] f7;
    f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
    drive(v, 2'($urandom), 3'($urandom), f7, 1'($urandom), $urandom, $urandom, $urandom);
  endtask

  // one clock: advance the model from the inputs present before the edge
  task automatic cycle();
    bit xin, xout, flush;
    logic [3:0] op;
    logic [31:0] sel;
    flush = bus.Flush;
    xin   = bus.InValid && exp_ready();
    xout  = m_valid && bus.OutReady;
    op    = ref_op(bus.ALUOp, bus.Funct3, bus.Funct7);
    sel   = bus.ALUSrc ? bus.ImmG : bus.RD2;
    @(posedge clk);
    #1;
    if (flush) m_valid = 0;
    else begin
      if (xout && m_ill && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      if (xin) begin
        m_valid = 1;
        m_op    = op;
        m_ill   = (op == 4'hF);
        m_a     = m_ill ? 32'd0 : bus.RD1;
        m_b     = m_ill ? 32'd0 : ((op == 4'h4 || op == 4'h5) ? sel % 32 : sel);
      end else if (xout) m_valid = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.Flush = 0; bus.OutReady = 0;
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_ill = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.OutValid, bus.SrcA, bus.SrcB, bus.Operation, bus.Illegal, bus.IllegalCount} !== 78'd0)
      begin errors++; $display("FAIL reset_state: got v=%b a=%h b=%h op=%h ill=%b cnt=%0d want all zero",
        bus.OutValid, bus.SrcA, bus.SrcB, bus.Operation, bus.Illegal, bus.IllegalCount); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_rtype_add();
    drive(1, 2'b10, 3'b000, 7'd0, 0, 32'd5, 32'd7, 32'd99);
    cycle();
    bus.InValid = 0;
    checks++;
    if ({bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b0010, 32'd5, 32'd7})
      begin errors++; $display("FAIL rtype_add: got v=%b op=%b a=%0d b=%0d want v=1 op=0010 a=5 b=7",
        bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB); end
  endtask

  task automatic test_slli();
    bus.OutReady = 1;
    drive(1, 2'b11, 3'b001, 7'd0, 1, 32'h1234, 32'h55, 32'hFFFFFFE3);
    cycle();
    bus.InValid = 0; bus.OutReady = 0;
    checks++;
    if ({bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b0100, 32'h1234, 32'h3})
      begin errors++; $display("FAIL slli: got v=%b op=%b a=%h b=%h want v=1 op=0100 a=1234 b=00000003",
        bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB); end
  endtask

  task automatic test_backpressure();
    logic [68:0] snap;
    snap = {bus.Operation, bus.SrcA, bus.SrcB, bus.Illegal};
    bus.OutReady = 0;
    drive(1, 2'b10, 3'b110, 7'd0, 0, 32'hAAAA0000, 32'h0000BBBB, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.InReady !== 1'b0)
        begin errors++; $display("FAIL bp_inready[%0d]: got %b want 0", i, bus.InReady); end
      cycle();
      checks++;
      if ({bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB, bus.Illegal} !== {1'b1, snap})
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b op=%b a=%h b=%h want v=1 op=%b a=%h b=%h",
          i, bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB, snap[68:65], snap[64:33], snap[32:1]); end
    end
    bus.OutReady = 1;
    #1;
    checks++;
    if (bus.InReady !== 1'b1)
      begin errors++; $display("FAIL bp_release_inready: got %b want 1", bus.InReady); end
    cycle();
    bus.InValid = 0;
    checks++;
    if ({bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b0001, 32'hAAAA0000, 32'h0000BBBB})
      begin errors++; $display("FAIL bp_replace: got v=%b op=%b a=%h b=%h want v=1 op=0001 a=aaaa0000 b=0000bbbb",
        bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB); end
  endtask

  task automatic test_illegal();
    bus.OutReady = 1;
    drive(1, 2'b10, 3'b001, 7'd0, 0, 32'hDEAD, 32'hBEEF, 32'd1);
    cycle();
    bus.InValid = 0;
    checks++;
    if ({bus.OutValid, bus.Operation, bus.Illegal, bus.SrcA, bus.SrcB, bus.IllegalCount} !==
        {1'b1, 4'hF, 1'b1, 64'd0, 8'd0})
      begin errors++; $display("FAIL illegal_decode: got v=%b op=%b ill=%b a=%h b=%h cnt=%0d want v=1 op=1111 ill=1 a=0 b=0 cnt=0",
        bus.OutValid, bus.Operation, bus.Illegal, bus.SrcA, bus.SrcB, bus.IllegalCount); end
    cycle();
    checks++;
    if ({bus.OutValid, bus.IllegalCount} !== {1'b0, 8'd1})
      begin errors++; $display("FAIL illegal_count1: got v=%b cnt=%0d want v=0 cnt=1", bus.OutValid, bus.IllegalCount); end
  endtask

  task automatic test_flush();
    // flush a held illegal entry with OutReady low, then with OutReady high
    for (int k = 0; k < 2; k++) begin
      bus.OutReady = 0;
      drive(1, 2'b01, 3'b010, 7'd0, 0, 32'd1, 32'd2, 32'd3);
      cycle();
      bus.Flush = 1; bus.OutReady = 1'(k);
      drive(1, 2'b00, 3'b000, 7'd0, 0, 32'h77, 32'h88, 32'd0);
      #1;
      checks++;
      if (bus.InReady !== 1'b0)
        begin errors++; $display("FAIL flush_inready[%0d]: got %b want 0", k, bus.InReady); end
      cycle();
      bus.Flush = 0; bus.InValid = 0;
      checks++;
      if ({bus.OutValid, bus.IllegalCount} !== {1'b0, 8'd1})
        begin errors++; $display("FAIL flush_drop[%0d]: got v=%b cnt=%0d want v=0 cnt=1", k, bus.OutValid, bus.IllegalCount); end
      cycle();
      checks++;
      if (bus.OutValid !== 1'b0)
        begin errors++; $display("FAIL flush_nocapture[%0d]: got v=%b want 0", k, bus.OutValid); end
    end
  endtask

  task automatic test_saturation();
    bus.OutReady = 1;
    for (int i = 0; i < 300; i++) begin
      drive(1, 2'b10, 3'($urandom), 7'($urandom_range(1, 127)), 1'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    bus.InValid = 0;
    cycle();
    checks++;
    if ({bus.OutValid, bus.IllegalCount} !== {1'b0, 8'd255} || m_cnt !== 8'd255)
      begin errors++; $display("FAIL illegal_saturate: got v=%b cnt=%0d want v=0 cnt=255", bus.OutValid, bus.IllegalCount); end
  endtask

  task automatic test_beq_reset();
    bus.OutReady = 0;
    drive(1, 2'b01, 3'b000, 7'd5, 0, 32'hA5, 32'hA5, 32'd0);
    cycle();
    bus.InValid = 0;
    checks++;
    if ({bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b1000, 32'hA5, 32'hA5})
      begin errors++; $display("FAIL beq: got v=%b op=%b a=%h b=%h want v=1 op=1000 a=a5 b=a5",
        bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB); end
    cycle();
    bus.OutReady = 1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.OutValid, bus.SrcA, bus.SrcB, bus.Operation, bus.Illegal, bus.IllegalCount} !== 78'd0)
      begin errors++; $display("FAIL async_reset: got v=%b a=%h b=%h op=%h ill=%b cnt=%0d want all zero",
        bus.OutValid, bus.SrcA, bus.SrcB, bus.Operation, bus.Illegal, bus.IllegalCount); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      bus.OutReady = ($urandom_range(0, 9) < 6);
      bus.Flush    = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (bus.InReady !== exp_ready())
        begin errors++; $display("FAIL rand_inready[%0d]: got %b want %b", i, bus.InReady, exp_ready()); end
      cycle();
      checks++;
      if ({bus.OutValid, bus.IllegalCount} !== {m_valid, m_cnt} ||
          (m_valid && {bus.Operation, bus.SrcA, bus.SrcB, bus.Illegal} !== {m_op, m_a, m_b, m_ill}))
        begin errors++; $display("FAIL rand_out[%0d]: got v=%b op=%h a=%h b=%h ill=%b cnt=%0d want v=%b op=%h a=%h b=%h ill=%b cnt=%0d",
          i, bus.OutValid, bus.Operation, bus.SrcA, bus.SrcB, bus.Illegal, bus.IllegalCount,
          m_valid, m_op, m_a, m_b, m_ill, m_cnt); end
    end
  endtask

  initial begin
    bus.Flush = 0; bus.OutReady = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_rtype_add();
    test_slli();
    test_backpressure();
    test_illegal();
    test_flush();
    test_saturation();
    test_beq_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
